// File: rtl/simd_alu_pkg.sv
// Shared constants for the 45-bit segmented SIMD adder and the blocks that
// consume its results: segment geometry, mode encodings and lane counts.
package simd_alu_pkg;

  localparam logic [1:0] MODE_27x18   = 2'b00;
  localparam logic [1:0] MODE_SUM_9x9 = 2'b01;
  localparam logic [1:0] MODE_SUM_4x4 = 2'b10;

  localparam int SEG_W   [4] = '{17, 10, 8, 10};
  localparam int SEG_LSB [4] = '{0, 17, 27, 35};

  // Mode 2'b11 is an alias of the 4-lane mode.
  function automatic int lanes_per_mode(input logic [1:0] mode);
    case (mode)
      MODE_27x18:   return 1;
      MODE_SUM_9x9: return 2;
      default:      return 4;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_select.sv
// Combinational lane extractor: picks one lane of an adder result word and
// forms {carry, sum bits}, plus the lane overflow flag and last-lane flag.
module simd_lane_select
  import simd_alu_pkg::*;
#(
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic [1:0]  mode,
  input  logic [1:0]  lane,
  input  logic [44:0] s,
  input  logic [7:0]  cout,
  output logic [46:0] value,
  output logic        ovf,
  output logic        last
);

  int          lsb;
  int          width;
  logic [1:0]  carry;
  logic [46:0] mask;

  // Chained lanes take the carry of their top segment only; lower segment
  // carries are internal to the chain and carry no meaning here.
  always_comb begin
    lsb   = 0;
    width = 45;
    carry = cout[7:6];
    case (mode)
      MODE_27x18: width = 45;
      MODE_SUM_9x9: begin
        if (lane == 2'd0) begin
          width = 27;
          carry = cout[3:2];
        end else begin
          lsb   = 27;
          width = 18;
        end
      end
      default: begin
        lsb   = SEG_LSB[lane];
        width = SEG_W[lane];
        carry = cout[{lane, 1'b0} +: 2];
      end
    endcase
    mask  = (47'd1 << width) - 47'd1;
    value = ((47'(s) >> lsb) & mask) | (47'(carry) << width);
    if (SIGN_EXT && carry[1]) begin
      value = value | ~((47'd1 << (width + 2)) - 47'd1);
    end
    ovf  = |carry;
    last = (int'(lane) == lanes_per_mode(mode) - 1);
  end

endmodule

// File: rtl/simd_result_unpacker.sv
// Captures one SIMD adder result word and streams its lanes out one per
// cycle over a valid/ready handshake, with no bubble between words.
module simd_result_unpacker
  import simd_alu_pkg::*;
#(
  parameter int OUT_W    = 48,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       USE_SIMD,
  input  logic [44:0]      S,
  input  logic [7:0]       result_SIMD_carry_out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             out_ovf
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]       state;
  logic [1:0]       lane_cnt;
  logic [1:0]       cap_mode;
  logic [44:0]      cap_s;
  logic [7:0]       cap_cout;

  logic             out_fire;
  logic             accept;
  logic [1:0]       sel_mode;
  logic [1:0]       sel_lane;
  logic [44:0]      sel_s;
  logic [7:0]       sel_cout;
  logic [46:0]      sel_value;
  logic             sel_ovf;
  logic             sel_last;
  logic [OUT_W-1:0] sel_ext;

  assign out_valid = (state == ST_DRAIN);
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = (state == ST_IDLE) | (out_fire & out_last);
  assign accept    = in_valid & in_ready;

  // Outputs are registered, so the next lane is formed one cycle early: lane 0
  // straight from the incoming word on accept, later lanes from the capture.
  always_comb begin
    sel_mode = accept ? USE_SIMD : cap_mode;
    sel_s    = accept ? S : cap_s;
    sel_cout = accept ? result_SIMD_carry_out : cap_cout;
    sel_lane = accept ? 2'd0 : lane_cnt + 2'd1;
  end

  simd_lane_select #(
    .SIGN_EXT(SIGN_EXT)
  ) u_lane_select (
    .mode  (sel_mode),
    .lane  (sel_lane),
    .s     (sel_s),
    .cout  (sel_cout),
    .value (sel_value),
    .ovf   (sel_ovf),
    .last  (sel_last)
  );

  always_comb begin
    sel_ext       = (SIGN_EXT && sel_value[46]) ? '1 : '0;
    sel_ext[46:0] = sel_value;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      lane_cnt <= 2'd0;
      cap_mode <= 2'd0;
      cap_s    <= '0;
      cap_cout <= '0;
      out_data <= '0;
      out_lane <= 2'd0;
      out_last <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      state    <= ST_DRAIN;
      lane_cnt <= 2'd0;
      cap_mode <= USE_SIMD;
      cap_s    <= S;
      cap_cout <= result_SIMD_carry_out;
      out_data <= sel_ext;
      out_lane <= 2'd0;
      out_last <= sel_last;
      out_ovf  <= sel_ovf;
    end else if (out_fire) begin
      if (out_last) begin
        state <= ST_IDLE;
      end else begin
        lane_cnt <= sel_lane;
        out_data <= sel_ext;
        out_lane <= sel_lane;
        out_last <= sel_last;
        out_ovf  <= sel_ovf;
      end
    end
  end

endmodule

// File: tb/tb_simd_result_unpacker.sv
// Directed self-checking bench for simd_result_unpacker: lane maps per mode,
// stalls, back-to-back words, input isolation and mid-drain reset.
module tb_simd_result_unpacker;

  logic        clk;
  logic        reset;
  logic [1:0]  use_simd;
  logic [44:0] s;
  logic [7:0]  cout;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  simd_result_unpacker #(
    .OUT_W   (48),
    .SIGN_EXT(1'b0)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .USE_SIMD              (use_simd),
    .S                     (s),
    .result_SIMD_carry_out (cout),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_lane              (out_lane),
    .out_last              (out_last),
    .out_ovf               (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 4-lane values, written directly from the segment map.
  function automatic logic [47:0] lane4(input logic [44:0] sv, input logic [7:0] cv, input int l);
    case (l)
      0:       return {29'd0, cv[1:0], sv[16:0]};
      1:       return {36'd0, cv[3:2], sv[26:17]};
      2:       return {38'd0, cv[5:4], sv[34:27]};
      default: return {36'd0, cv[7:6], sv[44:35]};
    endcase
  endfunction

  function automatic logic ovf4(input logic [7:0] cv, input int l);
    case (l)
      0:       return |cv[1:0];
      1:       return |cv[3:2];
      2:       return |cv[5:4];
      default: return |cv[7:6];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [1:0] m, input logic [44:0] sv, input logic [7:0] cv);
    use_simd = m;
    s        = sv;
    cout     = cv;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    use_simd = 2'd0; s = '0; cout = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 48'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL reset_out_lane got %0d exp 0", out_lane); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_mode_27x18();
    logic [47:0] exp_d;
    exp_d = {1'b0, 2'b11, 45'h1_2345_6789AB};
    out_ready = 1'b0;
    drive_word(2'b00, 45'h1_2345_6789AB, 8'b1100_0000);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m00_valid got %b exp 1", out_valid); end
    checks++; if (out_lane !== 2'd0) begin errors++; $display("FAIL m00_lane got %0d exp 0", out_lane); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL m00_last got %b exp 1", out_last); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL m00_ovf got %b exp 1", out_ovf); end
    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL m00_data got %h exp %h", out_data, exp_d); end
    tick();
    checks++; if (out_data !== exp_d || out_valid !== 1'b1) begin errors++; $display("FAIL m00_hold got %h/%b exp %h/1", out_data, out_valid, exp_d); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL m00_in_ready_stall got %b exp 0", in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL m00_in_ready_last got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m00_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_sum_4x4();
    logic [47:0] exp_d [4];
    exp_d[0] = 48'h1FFFF; exp_d[1] = 48'h3FF; exp_d[2] = 48'hFF; exp_d[3] = 48'h3FF;
    out_ready = 1'b1;
    drive_word(2'b10, '1, 8'h00);
    tick();
    in_valid = 1'b0;
    for (int l = 0; l < 4; l++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m10_valid lane %0d got %b exp 1", l, out_valid); end
      checks++; if (out_lane !== 2'(l)) begin errors++; $display("FAIL m10_lane got %0d exp %0d", out_lane, l); end
      checks++; if (out_data !== exp_d[l]) begin errors++; $display("FAIL m10_data lane %0d got %h exp %h", l, out_data, exp_d[l]); end
      checks++; if (out_last !== (l == 3)) begin errors++; $display("FAIL m10_last lane %0d got %b exp %b", l, out_last, l == 3); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL m10_ovf lane %0d got %b exp 0", l, out_ovf); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m10_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_stall_9x9();
    logic [44:0] sv;
    logic [7:0]  cv;
    logic [47:0] l0;
    logic [47:0] l1;
    sv = 45'h1ABC_DEF0_1234;
    cv = 8'b1000_0100;
    l0 = {19'd0, cv[3:2], sv[26:0]};
    l1 = {28'd0, cv[7:6], sv[44:27]};
    out_ready = 1'b0;
    drive_word(2'b01, sv, cv);
    tick();
    in_valid = 1'b0; s = '0; use_simd = 2'b10; cout = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_data !== l0) begin
        errors++; $display("FAIL m01_stall cyc %0d got %b/%0d/%h exp 1/0/%h", c, out_valid, out_lane, out_data, l0);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL m01_in_ready cyc %0d got %b exp 0", c, in_ready); end
      tick();
    end
    checks++; if (out_ovf !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL m01_l0_flags got ovf %b last %b exp 1 0", out_ovf, out_last); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL m01_in_ready_l0 got %b exp 0", in_ready); end
    tick();
    checks++; if (out_lane !== 2'd1 || out_data !== l1) begin errors++; $display("FAIL m01_l1 got %0d/%h exp 1/%h", out_lane, out_data, l1); end
    checks++; if (out_last !== 1'b1 || out_ovf !== 1'b1) begin errors++; $display("FAIL m01_l1_flags got last %b ovf %b exp 1 1", out_last, out_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL m01_in_ready_last got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m01_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [44:0] sw [2];
    logic [7:0]  cw [2];
    logic [47:0] exp_d;
    sw[0] = 45'h0AAA_5555_1234; cw[0] = 8'b0110_1100;
    sw[1] = 45'h1234_5678_9ABC; cw[1] = 8'b0000_0100;
    out_ready = 1'b1;
    drive_word(2'b10, sw[0], cw[0]);
    tick();
    drive_word(2'b10, sw[1], cw[1]);
    for (int b = 0; b < 8; b++) begin
      exp_d = lane4(sw[b / 4], cw[b / 4], b % 4);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got %b exp 1", b, out_valid); end
      checks++; if (out_lane !== 2'(b % 4) || out_data !== exp_d) begin
        errors++; $display("FAIL b2b_data beat %0d got %0d/%h exp %0d/%h", b, out_lane, out_data, b % 4, exp_d);
      end
      checks++; if (out_ovf !== ovf4(cw[b / 4], b % 4)) begin errors++; $display("FAIL b2b_ovf beat %0d got %b exp %b", b, out_ovf, ovf4(cw[b / 4], b % 4)); end
      checks++; if (in_ready !== (b % 4 == 3)) begin errors++; $display("FAIL b2b_in_ready beat %0d got %b exp %b", b, in_ready, b % 4 == 3); end
      tick();
      if (b == 3) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_mode11_isolation();
    logic [44:0] sv;
    logic [7:0]  cv;
    sv = 45'h0F0F_1234_5678;
    cv = 8'b1101_1000;
    out_ready = 1'b1;
    drive_word(2'b11, sv, cv);
    tick();
    in_valid = 1'b0; use_simd = 2'b00; s = '1; cout = 8'h00;
    for (int l = 0; l < 4; l++) begin
      checks++; if (out_lane !== 2'(l) || out_data !== lane4(sv, cv, l)) begin
        errors++; $display("FAIL m11_data lane %0d got %0d/%h exp %h", l, out_lane, out_data, lane4(sv, cv, l));
      end
      checks++; if (out_ovf !== ovf4(cv, l) || out_last !== (l == 3)) begin
        errors++; $display("FAIL m11_flags lane %0d got ovf %b last %b exp %b %b", l, out_ovf, out_last, ovf4(cv, l), l == 3);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m11_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    logic [44:0] sv;
    sv = 45'h1555_AAAA_5555;
    out_ready = 1'b1;
    drive_word(2'b10, sv, 8'h55);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    checks++; if (out_lane !== 2'd2) begin errors++; $display("FAIL rst_pre_lane got %0d exp 2", out_lane); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 48'd0 || out_lane !== 2'd0) begin errors++; $display("FAIL rst_outputs got %h/%0d exp 0/0", out_data, out_lane); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    drive_word(2'b10, 45'h0123_4567_89AB, 8'b0000_0011);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0) begin errors++; $display("FAIL rst_restart got %b/%0d exp 1/0", out_valid, out_lane); end
    checks++; if (out_data !== lane4(45'h0123_4567_89AB, 8'b0000_0011, 0) || out_ovf !== 1'b1) begin
      errors++; $display("FAIL rst_restart_data got %h/%b exp %h/1", out_data, out_ovf, lane4(45'h0123_4567_89AB, 8'b0000_0011, 0));
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_mode_27x18();
    test_sum_4x4();
    test_stall_9x9();
    test_back_to_back();
    test_mode11_isolation();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
